// File: rtl/rv_adc_avg.sv
// rtl/rv_adc_avg.sv - multi-channel ADC oversampling averager with min/max tracking and threshold alarms
module rv_adc_avg #(
  parameter int NCH     = 8,
  parameter int DW      = 12,
  parameter int AVG_MAX = 6,
  parameter int AW      = 5
) (
  input  logic                   clk,
  input  logic                   xreset,
  input  logic [AW-1:0]          adr,
  input  logic                   cs,
  output logic                   rdy,
  input  logic [3:0]             we,
  input  logic                   re,
  input  logic [31:0]            dw,
  output logic [31:0]            dr,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [$clog2(NCH)-1:0] s_ch,
  input  logic [DW-1:0]          s_data,
  output logic                   irq
);
  localparam int CW  = $clog2(NCH);
  localparam int ACW = DW + AVG_MAX;
  localparam logic [AW-1:0] A_CTRL  = AW'(2*NCH);
  localparam logic [AW-1:0] A_ALARM = AW'(2*NCH+1);
  localparam logic [AW-1:0] A_THR   = AW'(2*NCH+2);
  localparam logic [AW-1:0] A_MASK  = AW'(2*NCH+3);
  localparam logic [2:0]    AMAX    = 3'(AVG_MAX);

  logic [ACW-1:0]     acc [NCH];
  logic [AVG_MAX-1:0] cnt [NCH];
  logic [DW-1:0]      avg [NCH];
  logic [DW-1:0]      mn  [NCH];
  logic [DW-1:0]      mx  [NCH];
  logic [NCH-1:0]     newf, alarm, mask;
  logic               en, busy;
  logic [2:0]         n;
  logic [DW-1:0]      thr_hi, thr_lo;
  logic [AW-1:0]      rd_adr;

  logic [31:0]        bm, ctrl_word, thr_word, mask_word, ctrl_nxt, thr_nxt, mask_nxt, rd_val;
  logic               wr, wr_ctrl, wr_alarm, wr_thr, wr_mask, acc_clr, clr_mm, take, done, hit, rd_start;
  logic [NCH-1:0]     alarm_clr, take_k, upd;
  logic [2:0]         neff;
  logic [ACW-1:0]     sum, sh;
  logic [AVG_MAX:0]   cnt_nxt, cnt_tgt;
  logic [DW-1:0]      res;

  assign bm       = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  assign wr       = cs & (|we);
  assign wr_ctrl  = wr && (adr == A_CTRL);
  assign wr_alarm = wr && (adr == A_ALARM);
  assign wr_thr   = wr && (adr == A_THR);
  assign wr_mask  = wr && (adr == A_MASK);
  // a byte0 CTRL write discards partial sums, so the stream is held off that cycle
  assign acc_clr  = cs & we[0] & (adr == A_CTRL);
  assign clr_mm   = wr_ctrl & we[1] & dw[9];
  assign s_ready  = en & ~acc_clr;
  assign take     = s_valid & s_ready & (int'(s_ch) < NCH);
  assign rd_start = cs & re & ~busy;
  assign rdy      = ~(rd_start & xreset);

  always_comb begin
    ctrl_word = '0;
    ctrl_word[8] = en;
    ctrl_word[2:0] = n;
    thr_word = '0;
    thr_word[16+:DW] = thr_hi;
    thr_word[0+:DW] = thr_lo;
    mask_word = '0;
    mask_word[NCH-1:0] = mask;
    ctrl_nxt = (ctrl_word & ~bm) | (dw & bm);
    thr_nxt  = (thr_word & ~bm) | (dw & bm);
    mask_nxt = (mask_word & ~bm) | (dw & bm);
    alarm_clr = wr_alarm ? (dw[NCH-1:0] & bm[NCH-1:0]) : '0;
  end

  always_comb begin
    neff    = (n > AMAX) ? AMAX : n;
    sum     = acc[s_ch] + ACW'(s_data);
    sh      = sum >> neff;
    res     = sh[DW-1:0];
    cnt_nxt = {1'b0, cnt[s_ch]} + 1'b1;
    cnt_tgt = (AVG_MAX+1)'(1) << neff;
    done    = take && (cnt_nxt == cnt_tgt);
    hit     = mask[s_ch] & ((res > thr_hi) | (res < thr_lo));
    for (int k = 0; k < NCH; k++) begin
      take_k[k] = take && (s_ch == CW'(k));
      upd[k]    = done && (s_ch == CW'(k));
    end
  end

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NCH; k++) begin
      if (adr == AW'(k)) begin
        rd_val[31] = newf[k];
        rd_val[DW-1:0] = avg[k];
      end
      if (adr == AW'(NCH+k)) begin
        rd_val[16+:DW] = mx[k];
        rd_val[0+:DW] = mn[k];
      end
    end
    if (adr == A_CTRL)  rd_val = ctrl_word;
    if (adr == A_ALARM) rd_val[NCH-1:0] = alarm;
    if (adr == A_THR)   rd_val = thr_word;
    if (adr == A_MASK)  rd_val = mask_word;
  end

  always_ff @(posedge clk) begin
    if (!xreset) begin
      busy   <= 1'b0;
      rd_adr <= '0;
      dr     <= '0;
      irq    <= 1'b0;
      en     <= 1'b0;
      n      <= '0;
      thr_hi <= '0;
      thr_lo <= '0;
      mask   <= '0;
      newf   <= '0;
      alarm  <= '0;
      for (int k = 0; k < NCH; k++) begin
        acc[k] <= '0;
        cnt[k] <= '0;
        avg[k] <= '0;
        mn[k]  <= '1;
        mx[k]  <= '0;
      end
    end else begin
      busy <= rd_start;
      if (rd_start) begin
        dr     <= rd_val;
        rd_adr <= adr;
      end
      irq <= |(alarm & mask);
      if (wr_ctrl) begin
        en <= ctrl_nxt[8];
        n  <= ctrl_nxt[2:0];
      end
      if (wr_thr) begin
        thr_hi <= thr_nxt[16+:DW];
        thr_lo <= thr_nxt[0+:DW];
      end
      if (wr_mask) mask <= mask_nxt[NCH-1:0];
      for (int k = 0; k < NCH; k++) begin
        if (acc_clr || upd[k]) begin
          acc[k] <= '0;
          cnt[k] <= '0;
        end else if (take_k[k]) begin
          acc[k] <= sum;
          cnt[k] <= cnt_nxt[AVG_MAX-1:0];
        end
        if (upd[k]) avg[k] <= res;
        // a result landing on the read-completion edge wins over the read clear
        if (upd[k]) newf[k] <= 1'b1;
        else if (busy && rd_adr == AW'(k)) newf[k] <= 1'b0;
        if (upd[k] && hit) alarm[k] <= 1'b1;
        else if (alarm_clr[k]) alarm[k] <= 1'b0;
        if (clr_mm) begin
          mn[k] <= upd[k] ? res : '1;
          mx[k] <= upd[k] ? res : '0;
        end else if (upd[k]) begin
          if (res < mn[k]) mn[k] <= res;
          if (res > mx[k]) mx[k] <= res;
        end
      end
    end
  end
endmodule

// File: tb/tb_rv_adc_avg.sv
// tb/tb_rv_adc_avg.sv - self-checking bench for rv_adc_avg against a queue-based averaging model
module tb_rv_adc_avg;
  localparam int NCH = 8;
  localparam int DW = 12;
  localparam int AW = 5;
  localparam int A_CTRL = 16;
  localparam int A_ALARM = 17;
  localparam int A_THR = 18;
  localparam int A_MASK = 19;

  logic clk = 0, xreset = 0, cs = 0, re = 0, s_valid = 0;
  logic rdy, s_ready, irq;
  logic [AW-1:0] adr = '0;
  logic [3:0] we = '0;
  logic [31:0] dw = '0, dr;
  logic [2:0] s_ch = '0;
  logic [DW-1:0] s_data = '0;

  rv_adc_avg #(.NCH(NCH), .DW(DW), .AVG_MAX(6), .AW(AW)) dut (
    .clk(clk), .xreset(xreset), .adr(adr), .cs(cs), .rdy(rdy), .we(we), .re(re),
    .dw(dw), .dr(dr), .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch),
    .s_data(s_data), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  int m_q[NCH][$];
  logic [11:0] m_avg[NCH], m_min[NCH], m_max[NCH];
  logic m_new[NCH], m_alarm[NCH];
  logic m_en;
  logic [2:0] m_n;
  logic [11:0] m_hi, m_lo;
  logic [7:0] m_mask;

  function automatic void m_reset();
    for (int k = 0; k < NCH; k++) begin
      m_q[k].delete();
      m_avg[k] = 0; m_min[k] = 12'hFFF; m_max[k] = 0; m_new[k] = 0; m_alarm[k] = 0;
    end
    m_en = 0; m_n = 0; m_hi = 0; m_lo = 0; m_mask = 0;
  endfunction

  function automatic void m_push(int ch, int d);
    int ne, tot, a;
    ne = (m_n > 6) ? 6 : int'(m_n);
    m_q[ch].push_back(d);
    if (m_q[ch].size() == (1 << ne)) begin
      tot = 0;
      for (int i = 0; i < m_q[ch].size(); i++) tot += m_q[ch][i];
      a = tot / (1 << ne);
      m_q[ch].delete();
      m_avg[ch] = 12'(a);
      m_new[ch] = 1;
      if (a < int'(m_min[ch])) m_min[ch] = 12'(a);
      if (a > int'(m_max[ch])) m_max[ch] = 12'(a);
      if (m_mask[ch] && (a > int'(m_hi) || a < int'(m_lo))) m_alarm[ch] = 1;
    end
  endfunction

  function automatic void m_write(int a, logic [31:0] d, logic [3:0] be);
    logic [31:0] bm, cur, nw;
    bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if (a == A_CTRL) begin
      cur = {23'b0, m_en, 5'b0, m_n};
      nw = (cur & ~bm) | (d & bm);
      m_en = nw[8]; m_n = nw[2:0];
      if (be[0]) for (int k = 0; k < NCH; k++) m_q[k].delete();
      if (be[1] && d[9]) for (int k = 0; k < NCH; k++) begin m_min[k] = 12'hFFF; m_max[k] = 0; end
    end else if (a == A_ALARM) begin
      for (int k = 0; k < NCH; k++) if (d[k] && bm[k]) m_alarm[k] = 0;
    end else if (a == A_THR) begin
      cur = {4'b0, m_hi, 4'b0, m_lo};
      nw = (cur & ~bm) | (d & bm);
      m_hi = nw[27:16]; m_lo = nw[11:0];
    end else if (a == A_MASK) begin
      cur = {24'b0, m_mask};
      nw = (cur & ~bm) | (d & bm);
      m_mask = nw[7:0];
    end
  endfunction

  function automatic logic [31:0] exp_word(int a);
    logic [31:0] w;
    w = '0;
    if (a < NCH) begin w[31] = m_new[a]; w[11:0] = m_avg[a]; end
    else if (a < 2*NCH) begin w[27:16] = m_max[a-NCH]; w[11:0] = m_min[a-NCH]; end
    else if (a == A_CTRL) begin w[8] = m_en; w[2:0] = m_n; end
    else if (a == A_ALARM) begin for (int k = 0; k < NCH; k++) w[k] = m_alarm[k]; end
    else if (a == A_THR) begin w[27:16] = m_hi; w[11:0] = m_lo; end
    else if (a == A_MASK) w[7:0] = m_mask;
    return w;
  endfunction

  function automatic logic m_irq();
    logic r;
    r = 0;
    for (int k = 0; k < NCH; k++) r |= m_alarm[k] & m_mask[k];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input int a, input logic [31:0] d, input logic [3:0] be);
    cs = 1; re = 0; we = be; adr = 5'(a); dw = d;
    @(posedge clk);
    m_write(a, d, be);
    #1; cs = 0; we = 0;
  endtask

  task automatic bus_read(input int a, output logic [31:0] d, output int lowc);
    cs = 1; re = 1; we = 0; adr = 5'(a);
    #1; lowc = 0;
    while (rdy !== 1'b1 && lowc < 8) begin @(posedge clk); #2; lowc++; end
    d = dr;
    @(posedge clk);
    if (a < NCH) m_new[a] = 0;
    #1; cs = 0; re = 0;
  endtask

  task automatic send(input int ch, input int d);
    int w;
    s_valid = 1; s_ch = 3'(ch); s_data = 12'(d);
    #1; w = 0;
    while (s_ready !== 1'b1 && w < 8) begin @(posedge clk); #2; w++; end
    if (s_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout ch%0d: s_ready=%b required 1", ch, s_ready);
      #1; s_valid = 0;
    end else begin
      @(posedge clk);
      m_push(ch, d);
      #1; s_valid = 0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    int lc;
    xreset = 0; tick(); tick();
    n_checks++; if (rdy !== 1 || irq !== 0 || s_ready !== 0 || dr !== 0) begin n_fail++;
      $display("FAIL reset_outputs: rdy=%b irq=%b s_ready=%b dr=%h required 1 0 0 0", rdy, irq, s_ready, dr); end
    xreset = 1; tick();
    m_reset();
    for (int a = 0; a < 2*NCH+6; a++) begin
      e = exp_word(a);
      bus_read(a, d, lc);
      n_checks++; if (d !== e || lc != 1) begin n_fail++;
        $display("FAIL reset_read[%0d]: got %h waits %0d required %h waits 1", a, d, lc, e); end
    end
    bus_read(NCH, d, lc);
    n_checks++; if (d !== 32'h0000_0FFF) begin n_fail++;
      $display("FAIL reset_minmax0: got %h required 00000fff", d); end
    cs = 1; re = 1; adr = 0; #1;
    n_checks++; if (rdy !== 0) begin n_fail++; $display("FAIL read_wait: rdy=%b required 0", rdy); end
    xreset = 0; #1;
    n_checks++; if (rdy !== 1) begin n_fail++; $display("FAIL reset_mid_read: rdy=%b required 1", rdy); end
    @(posedge clk); #1; cs = 0; re = 0; xreset = 1; tick();
    m_reset();
  endtask

  task automatic test_avg();
    logic [31:0] d;
    int lc;
    bus_write(A_CTRL, 32'h104, 4'hF);
    for (int i = 0; i < 16; i++) send(2, 100 + i);
    bus_read(2, d, lc);
    n_checks++; if (d !== 32'h8000_006B) begin n_fail++; $display("FAIL avg2_first: got %h required 8000006b", d); end
    bus_read(2, d, lc);
    n_checks++; if (d !== 32'h0000_006B) begin n_fail++; $display("FAIL avg2_second: got %h required 0000006b", d); end
  endtask

  task automatic test_minmax();
    logic [31:0] d;
    int lc;
    bus_write(A_CTRL, 32'h100, 4'hF);
    send(0, 10); send(0, 4000); send(0, 7);
    bus_read(NCH, d, lc);
    n_checks++; if (d !== 32'h0FA0_0007) begin n_fail++; $display("FAIL minmax0: got %h required 0fa00007", d); end
    bus_read(0, d, lc);
    n_checks++; if (d !== 32'h8000_0007) begin n_fail++; $display("FAIL avg0_pass: got %h required 80000007", d); end
    bus_write(A_CTRL, 32'h300, 4'hF);
    for (int k = 0; k < NCH; k++) begin
      bus_read(NCH + k, d, lc);
      n_checks++; if (d !== 32'h0000_0FFF) begin n_fail++; $display("FAIL minmax_clr[%0d]: got %h required 00000fff", k, d); end
    end
    bus_read(A_CTRL, d, lc);
    n_checks++; if (d !== 32'h0000_0100) begin n_fail++; $display("FAIL ctrl_selfclear: got %h required 00000100", d); end
  endtask

  task automatic test_alarm();
    logic [31:0] d;
    int lc;
    bus_write(A_THR, (32'd3000 << 16) | 32'd500, 4'hF);
    bus_write(A_MASK, 32'h1, 4'hF);
    send(0, 3001);
    n_checks++; if (irq !== 0) begin n_fail++; $display("FAIL irq_early: irq=%b required 0", irq); end
    tick();
    n_checks++; if (irq !== 1) begin n_fail++; $display("FAIL irq_set: irq=%b required 1", irq); end
    send(1, 3001);
    bus_read(A_ALARM, d, lc);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL alarm_masked: got %h required 00000001", d); end
    bus_write(A_ALARM, 32'h1, 4'hF);
    tick();
    n_checks++; if (irq !== 0) begin n_fail++; $display("FAIL irq_clear: irq=%b required 0", irq); end
    send(0, 500); send(0, 3000);
    bus_read(A_ALARM, d, lc);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL alarm_strict: got %h required 00000000", d); end
    send(0, 499);
    bus_read(A_ALARM, d, lc);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL alarm_low: got %h required 00000001", d); end
    bus_write(A_ALARM, 32'h1, 4'hF);
  endtask

  task automatic test_same_edge();
    logic [31:0] d, e0;
    int lc;
    cs = 1; we = 4'hF; re = 0; adr = 5'(A_ALARM); dw = 32'h1;
    s_valid = 1; s_ch = 0; s_data = 12'd3001;
    @(posedge clk);
    m_write(A_ALARM, 32'h1, 4'hF); m_push(0, 3001);
    #1; cs = 0; we = 0; s_valid = 0;
    bus_read(A_ALARM, d, lc);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL alarm_set_vs_w1c: got %h required 00000001", d); end
    bus_write(A_ALARM, 32'h1, 4'hF);
    e0 = exp_word(0);
    cs = 1; re = 1; adr = 0;
    @(posedge clk); #1;
    s_valid = 1; s_ch = 0; s_data = 12'd1234; #1;
    n_checks++; if (rdy !== 1) begin n_fail++; $display("FAIL read_rdy_back: rdy=%b required 1", rdy); end
    @(posedge clk);
    m_push(0, 1234);
    #1; cs = 0; re = 0; s_valid = 0;
    n_checks++; if (dr !== e0) begin n_fail++; $display("FAIL same_edge_dr: got %h required %h", dr, e0); end
    bus_read(0, d, lc);
    n_checks++; if (d !== 32'h8000_04D2) begin n_fail++; $display("FAIL new_kept: got %h required 800004d2", d); end
    bus_read(0, d, lc);
    n_checks++; if (d !== 32'h0000_04D2) begin n_fail++; $display("FAIL new_cleared: got %h required 000004d2", d); end
  endtask

  task automatic test_ctrl();
    logic [31:0] d, e;
    int lc;
    bus_write(A_CTRL, 32'h102, 4'hF);
    send(3, 1000); send(3, 2000);
    bus_write(A_CTRL, 32'h0, 4'b0010);
    #1;
    n_checks++; if (s_ready !== 0) begin n_fail++; $display("FAIL disabled_ready: s_ready=%b required 0", s_ready); end
    bus_write(A_CTRL, 32'h100, 4'b0010);
    send(3, 3000); send(3, 4000);
    bus_read(3, d, lc);
    n_checks++; if (d !== 32'h8000_09C4) begin n_fail++; $display("FAIL resume_avg: got %h required 800009c4", d); end
    send(3, 1000); send(3, 1000);
    cs = 1; we = 4'hF; adr = 5'(A_CTRL); dw = 32'h102;
    s_valid = 1; s_ch = 3; s_data = 12'd4095; #1;
    n_checks++; if (s_ready !== 0) begin n_fail++; $display("FAIL ctrl_write_ready: s_ready=%b required 0", s_ready); end
    @(posedge clk);
    m_write(A_CTRL, 32'h102, 4'hF);
    #1; cs = 0; we = 0; s_valid = 0;
    send(3, 8); send(3, 8); send(3, 8);
    bus_read(3, d, lc);
    n_checks++; if (d !== 32'h0000_09C4) begin n_fail++; $display("FAIL discard_partial: got %h required 000009c4", d); end
    send(3, 12);
    bus_read(3, d, lc);
    n_checks++; if (d !== 32'h8000_0009) begin n_fail++; $display("FAIL discard_avg: got %h required 80000009", d); end
    bus_write(A_CTRL, 32'h107, 4'hF);
    for (int i = 0; i < 63; i++) send(5, $urandom_range(4095));
    e = exp_word(5);
    bus_read(5, d, lc);
    n_checks++; if (d !== e || d[31] !== 0) begin n_fail++; $display("FAIL n7_63: got %h required %h", d, e); end
    send(5, $urandom_range(4095));
    e = exp_word(5);
    bus_read(5, d, lc);
    n_checks++; if (d !== e || d[31] !== 1) begin n_fail++; $display("FAIL n7_64: got %h required %h", d, e); end
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    int lc, nv;
    for (int r = 0; r < 6; r++) begin
      nv = $urandom_range(7);
      bus_write(A_CTRL, 32'h100 | 32'(nv), 4'hF);
      bus_write(A_THR, (32'($urandom_range(4095, 2500)) << 16) | 32'($urandom_range(1500)), 4'hF);
      bus_write(A_THR, $urandom, 4'b0011);
      bus_write(A_MASK, $urandom, 4'($urandom_range(15)));
      bus_write(25, 32'hFFFF_FFFF, 4'hF);
      for (int i = 0; i < 48; i++) begin
        if ($urandom_range(3) == 0) tick();
        send($urandom_range(NCH-1), $urandom_range(4095));
      end
      for (int a = 0; a < 2*NCH+6; a++) begin
        e = exp_word(a);
        bus_read(a, d, lc);
        n_checks++; if (d !== e) begin n_fail++; $display("FAIL rand_r%0d_a%0d: got %h required %h", r, a, d, e); end
      end
      tick();
      n_checks++; if (irq !== m_irq()) begin n_fail++; $display("FAIL rand_irq_r%0d: irq=%b required %b", r, irq, m_irq()); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_avg();
    test_minmax();
    test_alarm();
    test_same_edge();
    test_ctrl();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
